apb_master_fsm: RTL

//  APB4 master stage downstream of the AXI-Lite slave front end in the AXI-Lite to APB converter.

---
 rtl/apb_master_fsm_if.sv | 26 ++
 rtl/apb_master_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm_if.sv
// APB4 bus bundle between the converter's master stage and the downstream APB slave.
interface apb_master_fsm_if #(
    parameter int unsigned AW_APB = 32,
    parameter int unsigned DW_APB = 32
) ();
    logic [AW_APB-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DW_APB-1:0]   pwdata;
    logic [DW_APB/8-1:0] pstrb;
    logic [2:0]          pprot;
    logic [DW_APB-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_fsm.sv
// APB4 master stage of the AXI-Lite to APB converter: one SETUP/ACCESS transfer per request,
// one queued request per direction, PREADY timeout with forced error completion.
module apb_master_fsm #(
    parameter int unsigned AW_APB         = 32,
    parameter int unsigned DW_APB         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                axi_clk,
    input  logic                sys_areset,
    input  logic                start_write,
    input  logic                start_read,
    input  logic [AW_APB-1:0]   write_address,
    input  logic [AW_APB-1:0]   read_address,
    input  logic [DW_APB-1:0]   write_data,
    input  logic [DW_APB/8-1:0] be,
    input  logic [2:0]          wprot,
    input  logic [2:0]          rprot,
    output logic [DW_APB-1:0]   read_data,
    output logic                read_data_valid,
    output logic                done_write,
    output logic                slv_err,
    output logic                req_overflow,
    apb_master_fsm_if.master    apb
);
    localparam int unsigned SW   = DW_APB / 8;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] TSat  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q;
    logic              cur_write_q;
    logic [CntW-1:0]   tcnt_q;

    // pend_x stays set while direction x is queued or in flight
    logic              pend_w_q, pend_r_q;
    logic [AW_APB-1:0] w_addr_q, r_addr_q;
    logic [DW_APB-1:0] w_data_q;
    logic [SW-1:0]     w_be_q;
    logic [2:0]        w_prot_q, r_prot_q;

    logic [AW_APB-1:0] sel_waddr, sel_raddr;
    logic [DW_APB-1:0] sel_wdata;
    logic [SW-1:0]     sel_wbe;
    logic [2:0]        sel_wprot, sel_rprot;
    logic              timeout_hit;

    // IDLE bypass: a fresh strobe launches straight from the input bus
    always_comb begin
        sel_waddr   = pend_w_q ? w_addr_q : write_address;
        sel_wdata   = pend_w_q ? w_data_q : write_data;
        sel_wbe     = pend_w_q ? w_be_q   : be;
        sel_wprot   = pend_w_q ? w_prot_q : wprot;
        sel_raddr   = pend_r_q ? r_addr_q : read_address;
        sel_rprot   = pend_r_q ? r_prot_q : rprot;
        timeout_hit = (TIMEOUT_CYCLES != 0) && !apb.pready && (tcnt_q == TLast);
    end

    always_ff @(posedge axi_clk) begin
        if (sys_areset) begin
            state_q         <= StIdle;
            cur_write_q     <= 1'b0;
            tcnt_q          <= '0;
            pend_w_q        <= 1'b0;
            pend_r_q        <= 1'b0;
            w_addr_q        <= '0;
            r_addr_q        <= '0;
            w_data_q        <= '0;
            w_be_q          <= '0;
            w_prot_q        <= '0;
            r_prot_q        <= '0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            done_write      <= 1'b0;
            slv_err         <= 1'b0;
            req_overflow    <= 1'b0;
            apb.paddr       <= '0;
            apb.psel        <= 1'b0;
            apb.penable     <= 1'b0;
            apb.pwrite      <= 1'b0;
            apb.pwdata      <= '0;
            apb.pstrb       <= '0;
            apb.pprot       <= '0;
        end else begin
            done_write      <= 1'b0;
            read_data_valid <= 1'b0;

            if (start_write) begin
                if (pend_w_q) begin
                    req_overflow <= 1'b1;
                end else begin
                    pend_w_q <= 1'b1;
                    w_addr_q <= write_address;
                    w_data_q <= write_data;
                    w_be_q   <= be;
                    w_prot_q <= wprot;
                end
            end
            if (start_read) begin
                if (pend_r_q) begin
                    req_overflow <= 1'b1;
                end else begin
                    pend_r_q <= 1'b1;
                    r_addr_q <= read_address;
                    r_prot_q <= rprot;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_w_q || start_write) begin
                        state_q     <= StSetup;
                        cur_write_q <= 1'b1;
                        apb.psel    <= 1'b1;
                        apb.pwrite  <= 1'b1;
                        apb.paddr   <= sel_waddr;
                        apb.pwdata  <= sel_wdata;
                        apb.pstrb   <= sel_wbe;
                        apb.pprot   <= sel_wprot;
                    end else if (pend_r_q || start_read) begin
                        state_q     <= StSetup;
                        cur_write_q <= 1'b0;
                        apb.psel    <= 1'b1;
                        apb.pwrite  <= 1'b0;
                        apb.paddr   <= sel_raddr;
                        apb.pwdata  <= '0;
                        apb.pstrb   <= '0;
                        apb.pprot   <= sel_rprot;
                    end
                end
                StSetup: begin
                    state_q     <= StAccess;
                    apb.penable <= 1'b1;
                    tcnt_q      <= '0;
                end
                StAccess: begin
                    if (apb.pready || timeout_hit) begin
                        state_q     <= StIdle;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        slv_err     <= timeout_hit ? 1'b1 : apb.pslverr;
                        if (cur_write_q) begin
                            done_write <= 1'b1;
                            pend_w_q   <= 1'b0;
                        end else begin
                            read_data_valid <= 1'b1;
                            read_data       <= timeout_hit ? '0 : apb.prdata;
                            pend_r_q        <= 1'b0;
                        end
                    end else if (tcnt_q != TSat) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
